// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the GPR file write port.
// Two one-entry holding buffers (index 0 = EXU, 1 = LSU) are drained
// round-robin onto a registered write port. Each write carries a commit
// strobe and PC so the trace side can sample the file after retirement.
module regfile_wb_arbiter #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               exu_valid,
  output logic               exu_ready,
  input  logic [RADDR_W-1:0] exu_rd,
  input  logic [XLEN-1:0]    exu_data,
  input  logic [XLEN-1:0]    exu_pc,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [RADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]    lsu_data,
  input  logic [XLEN-1:0]    lsu_pc,
  output logic               rf_wen,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  input  logic [RADDR_W-1:0] query_rs1,
  input  logic [RADDR_W-1:0] query_rs2,
  output logic               pending_rs1,
  output logic               pending_rs2,
  output logic               busy
);

  // Requester-indexed views of the two write sources.
  logic [1:0]         in_valid;
  logic [RADDR_W-1:0] in_rd   [2];
  logic [XLEN-1:0]    in_data [2];
  logic [XLEN-1:0]    in_pc   [2];

  assign in_valid   = {lsu_valid, exu_valid};
  assign in_rd[0]   = exu_rd;
  assign in_rd[1]   = lsu_rd;
  assign in_data[0] = exu_data;
  assign in_data[1] = lsu_data;
  assign in_pc[0]   = exu_pc;
  assign in_pc[1]   = lsu_pc;

  logic [1:0]         hold_v;
  logic [RADDR_W-1:0] hold_rd   [2];
  logic [XLEN-1:0]    hold_data [2];
  logic [XLEN-1:0]    hold_pc   [2];
  logic [1:0]         grant;
  logic [1:0]         ready;
  logic               rr_reg;

  // Round-robin grant: a lone valid buffer always wins; on a tie rr picks.
  always_comb begin
    grant = hold_v;
    if (hold_v == 2'b11) begin
      grant = rr_reg ? 2'b10 : 2'b01;
    end
  end

  // A buffer accepts when empty or when it drains this very cycle.
  assign ready     = ~hold_v | grant;
  assign exu_ready = ready[0];
  assign lsu_ready = ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic               v_reg;
      logic [RADDR_W-1:0] rd_reg;
      logic [XLEN-1:0]    data_reg;
      logic [XLEN-1:0]    pc_reg;

      // Holding buffer: load on handshake, otherwise clear when granted.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v_reg    <= 1'b0;
          rd_reg   <= '0;
          data_reg <= '0;
          pc_reg   <= '0;
        end else if (in_valid[gi] && ready[gi]) begin
          v_reg    <= 1'b1;
          rd_reg   <= in_rd[gi];
          data_reg <= in_data[gi];
          pc_reg   <= in_pc[gi];
        end else if (grant[gi]) begin
          v_reg    <= 1'b0;
        end
      end

      assign hold_v[gi]    = v_reg;
      assign hold_rd[gi]   = rd_reg;
      assign hold_data[gi] = data_reg;
      assign hold_pc[gi]   = pc_reg;
    end
  endgenerate

  logic [RADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    sel_pc;

  // Payload of whichever buffer holds the grant.
  always_comb begin
    sel_rd   = grant[1] ? hold_rd[1]   : hold_rd[0];
    sel_data = grant[1] ? hold_data[1] : hold_data[0];
    sel_pc   = grant[1] ? hold_pc[1]   : hold_pc[0];
  end

  logic               rf_wen_reg;
  logic [RADDR_W-1:0] rf_waddr_reg;
  logic [XLEN-1:0]    rf_wdata_reg;
  logic               commit_valid_reg;
  logic [XLEN-1:0]    commit_pc_reg;

  // Registered write port plus rr update; x0 commits but never writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg           <= 1'b0;
      rf_wen_reg       <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      commit_valid_reg <= 1'b0;
      commit_pc_reg    <= '0;
    end else begin
      if (grant[0]) begin
        rr_reg <= 1'b1;
      end else if (grant[1]) begin
        rr_reg <= 1'b0;
      end
      if (|grant) begin
        rf_wen_reg       <= (sel_rd != '0);
        rf_waddr_reg     <= sel_rd;
        rf_wdata_reg     <= sel_data;
        commit_valid_reg <= 1'b1;
        commit_pc_reg    <= sel_pc;
      end else begin
        rf_wen_reg       <= 1'b0;
        commit_valid_reg <= 1'b0;
      end
    end
  end

  assign rf_wen       = rf_wen_reg;
  assign rf_waddr     = rf_waddr_reg;
  assign rf_wdata     = rf_wdata_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_pc    = commit_pc_reg;

  // Scoreboard lookups: a register is pending while buffered or on the port.
  logic [RADDR_W-1:0] query [2];
  logic [1:0]         pending;

  assign query[0] = query_rs1;
  assign query[1] = query_rs2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_query
      assign pending[gi] = (query[gi] != '0) &&
                           ((hold_v[0] && (hold_rd[0] == query[gi])) ||
                            (hold_v[1] && (hold_rd[1] == query[gi])) ||
                            (rf_wen_reg && (rf_waddr_reg == query[gi])));
    end
  endgenerate

  assign pending_rs1 = pending[0];
  assign pending_rs2 = pending[1];
  assign busy        = hold_v[0] | hold_v[1] | commit_valid_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a directed vector table,
// hand sequences for contention/backpressure/reset, and a random phase
// checked against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        exu_valid, lsu_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, query_rs1, query_rs2, rf_waddr;
  logic [63:0] exu_data, exu_pc, lsu_data, lsu_pc, rf_wdata, commit_pc;
  logic        rf_wen, commit_valid, pending_rs1, pending_rs2, busy;

  regfile_wb_arbiter #(.XLEN(64), .RADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
    .exu_data(exu_data), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_pc(lsu_pc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .pending_rs1(pending_rs1), .pending_rs2(pending_rs2), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each side owns at most one waiting write; on a tie the side whose turn
  // it is wins and the turn passes to the other side.
  typedef struct { logic [4:0] rd; logic [63:0] data; logic [63:0] pc; } txn_t;
  txn_t        slot [2];
  bit          slot_full [2];
  int          turn;
  txn_t        q_side [2][$];
  bit          m_wen, m_cv;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata, m_cpc;
  int          commits_seen;

  function automatic int m_winner();
    if (slot_full[0] && slot_full[1]) return turn;
    if (slot_full[0]) return 0;
    if (slot_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_pending(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (slot_full[s] && slot[s].rd == q) return 1'b1;
    return m_wen && (m_waddr == q);
  endfunction

  task automatic model_reset();
    slot_full[0] = 0; slot_full[1] = 0; turn = 0;
    q_side[0].delete(); q_side[1].delete();
    m_wen = 0; m_cv = 0; m_waddr = 0; m_wdata = 0; m_cpc = 0;
  endtask

  task automatic model_update();
    int w;
    bit   in_v [2];
    txn_t in_t [2];
    w = m_winner();
    in_v[0] = exu_valid; in_t[0] = '{exu_rd, exu_data, exu_pc};
    in_v[1] = lsu_valid; in_t[1] = '{lsu_rd, lsu_data, lsu_pc};
    if (w >= 0) begin
      m_wen = (slot[w].rd != 0); m_waddr = slot[w].rd; m_wdata = slot[w].data;
      m_cv = 1; m_cpc = slot[w].pc; turn = 1 - w;
    end else begin
      m_wen = 0; m_cv = 0;
    end
    for (int s = 0; s < 2; s++) begin
      if (in_v[s] && (!slot_full[s] || w == s)) begin
        slot[s] = in_t[s]; slot_full[s] = 1; q_side[s].push_back(in_t[s]);
      end else if (w == s) begin
        slot_full[s] = 0;
      end
    end
  endtask

  task automatic model_check();
    int  w;
    bit  found;
    w = m_winner();
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_pc", commit_pc, m_cpc);
    chk("exu_ready", exu_ready, !slot_full[0] || w == 0);
    chk("lsu_ready", lsu_ready, !slot_full[1] || w == 1);
    chk("pending_rs1", pending_rs1, m_pending(query_rs1));
    chk("pending_rs2", pending_rs2, m_pending(query_rs2));
    chk("busy", busy, slot_full[0] || slot_full[1] || m_cv);
    if (commit_valid) begin
      found = 0;
      commits_seen++;
      for (int s = 0; s < 2 && !found; s++) begin
        if (q_side[s].size() > 0 && q_side[s][0].rd == rf_waddr &&
            q_side[s][0].data == rf_wdata && q_side[s][0].pc == commit_pc) begin
          void'(q_side[s].pop_front());
          found = 1;
        end
      end
      chk("commit_in_order", found, 1'b1);
    end
  endtask

  task automatic cycle();
    #1 model_check();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    exu_valid = 0; lsu_valid = 0;
    exu_rd = 0; lsu_rd = 0; exu_data = 0; lsu_data = 0; exu_pc = 0; lsu_pc = 0;
    query_rs1 = 0; query_rs2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ev; logic [4:0] erd; logic [63:0] ed; logic [63:0] ep;
    logic lv; logic [4:0] lrd; logic [63:0] ld; logic [63:0] lp;
    logic [4:0] q1; logic [4:0] q2;
    logic wen; logic [4:0] waddr; logic [63:0] wdata; logic cv; logic [63:0] cpc;
    logic p1; logic p2; logic bsy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int exu_cnt, lsu_cnt, last_addr, total;
    bit got_ready;

    reset_n = 0;
    idle_inputs();
    model_reset();
    commits_seen = 0;

    tbl[0] = '{1, 5, 64'h1234, 64'h8000_0000, 0, 0, 0, 0, 5, 0, 0, 0, 64'h0,    0, 64'h0,          1, 0, 1};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0,                      5, 0, 1, 5, 64'h1234, 1, 64'h8000_0000, 1, 0, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0,                      5, 0, 0, 5, 64'h1234, 0, 64'h8000_0000, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 1, 0, 64'hdead, 64'h8000_0010,   0, 0, 0, 5, 64'h1234, 0, 64'h8000_0000, 0, 0, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 64'hdead, 1, 64'h8000_0010, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 64'hdead, 0, 64'h8000_0010, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 1, 7, 64'h77, 64'h8000_0020,     7, 0, 0, 0, 64'hdead, 0, 64'h8000_0010, 1, 0, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0,                      7, 0, 1, 7, 64'h77,   1, 64'h8000_0020, 1, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0,                      7, 0, 0, 7, 64'h77,   0, 64'h8000_0020, 0, 0, 0};

    // Reset state while reset is held.
    repeat (2) @(negedge clock);
    #1;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exu_ready", exu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    @(negedge clock);
    reset_n = 1;

    // Directed table: single EXU write, x0 commit, scoreboard lifetime.
    for (int i = 0; i < 9; i++) begin
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed; exu_pc = tbl[i].ep;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld; lsu_pc = tbl[i].lp;
      query_rs1 = tbl[i].q1; query_rs2 = tbl[i].q2;
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_rf_wen", i), rf_wen, tbl[i].wen);
      chk($sformatf("tbl%0d_rf_waddr", i), rf_waddr, tbl[i].waddr);
      chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_commit_valid", i), commit_valid, tbl[i].cv);
      chk($sformatf("tbl%0d_commit_pc", i), commit_pc, tbl[i].cpc);
      chk($sformatf("tbl%0d_pending_rs1", i), pending_rs1, tbl[i].p1);
      chk($sformatf("tbl%0d_pending_rs2", i), pending_rs2, tbl[i].p2);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      @(negedge clock);
      idle_inputs();
    end

    // Contention: both sides stream every cycle.
    do_reset();
    exu_cnt = 0; lsu_cnt = 0; last_addr = -1;
    for (int i = 0; i < 100; i++) begin
      exu_valid = 1; exu_rd = 1; exu_data = 64'(i); exu_pc = 64'h8000_1000 + 64'(i * 4);
      lsu_valid = 1; lsu_rd = 2; lsu_data = 64'(i) + 64'h100; lsu_pc = 64'h8000_2000 + 64'(i * 4);
      query_rs1 = 1; query_rs2 = 2;
      #1;
      if (commit_valid) begin
        if (rf_waddr == 5'd1) exu_cnt++; else lsu_cnt++;
        if (last_addr >= 0) chk("contention_alternates", (int'(rf_waddr) != last_addr), 1);
        last_addr = int'(rf_waddr);
      end
      #0 cycle();
    end
    total = exu_cnt + lsu_cnt;
    chk("contention_total", total, 98);
    chk("contention_balance", (exu_cnt - lsu_cnt <= 1) && (lsu_cnt - exu_cnt <= 1), 1);
    idle_inputs();
    repeat (4) cycle();
    chk("contention_drained", q_side[0].size() + q_side[1].size(), 0);

    // Backpressure: LSU holds a new request while its buffered entry loses.
    do_reset();
    commits_seen = 0;
    exu_valid = 1; exu_rd = 3; exu_data = 64'h33; exu_pc = 64'h8000_3000;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h44; lsu_pc = 64'h8000_3004;
    cycle();
    exu_valid = 0;
    lsu_valid = 1; lsu_rd = 5; lsu_data = 64'h55; lsu_pc = 64'h8000_3008;
    #1 chk("bp_lsu_ready_low", lsu_ready, 0);
    got_ready = 0;
    for (int i = 0; i < 10 && !got_ready; i++) begin
      #0;
      if (lsu_ready) got_ready = 1;
      cycle();
      chk("bp_payload_stable", {lsu_rd, lsu_data[7:0]}, {5'd5, 8'h55});
    end
    chk("bp_accepted_in_bound", got_ready, 1);
    idle_inputs();
    repeat (4) cycle();
    chk("bp_commit_count", commits_seen, 3);
    chk("bp_drained", q_side[0].size() + q_side[1].size(), 0);

    // Asynchronous reset with both buffers full.
    do_reset();
    exu_valid = 1; exu_rd = 9; exu_data = 64'h99; exu_pc = 64'h8000_4000;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 64'haa; lsu_pc = 64'h8000_4004;
    cycle();
    cycle();
    #2 reset_n = 0;
    idle_inputs();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rf_wen", rf_wen, 0);
    chk("arst_commit_valid", commit_valid, 0);
    chk("arst_exu_ready", exu_ready, 1);
    chk("arst_lsu_ready", lsu_ready, 1);
    @(negedge clock);
    reset_n = 1;
    model_reset();
    repeat (5) cycle();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      exu_valid = ($urandom_range(0, 2) != 0);
      exu_rd    = 5'($urandom_range(0, 7));
      exu_data  = {$urandom(), $urandom()};
      exu_pc    = {$urandom(), $urandom()};
      lsu_valid = ($urandom_range(0, 2) != 0);
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_data  = {$urandom(), $urandom()};
      lsu_pc    = {$urandom(), $urandom()};
      query_rs1 = 5'($urandom_range(0, 7));
      query_rs2 = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    repeat (5) cycle();
    chk("random_drained", q_side[0].size() + q_side[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
